// File: rtl/ifid_fetch_stage.sv
// rtl/ifid_fetch_stage.sv - instruction fetch stage with IF/ID register
// Keeps at most one Icache request outstanding and squashes responses made stale by a flush.
module ifid_fetch_stage #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] START_PC   = 32'h8000_0000,
    parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] Fetch_NextPC,
    input  logic                  EX_BranchFlag,
    input  logic                  Ctrl_ExcpFlag,
    input  logic                  Ctrl_Stall,
    output logic                  IFID_IcacheReq,
    output logic [ADDR_WIDTH-1:0] IFID_IcacheAddr,
    input  logic                  Icache_Valid,
    input  logic [INST_WIDTH-1:0] Icache_Data,
    output logic [ADDR_WIDTH-1:0] IFID_NowPC,
    output logic [INST_WIDTH-1:0] IFID_Inst,
    output logic                  IFID_Valid
);

    typedef enum logic [1:0] {S_BOOT, S_WAIT, S_HOLD} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic [ADDR_WIDTH-1:0] r_redirect;
    logic                  r_drop;
    logic [ADDR_WIDTH-1:0] r_now_pc;
    logic [INST_WIDTH-1:0] r_inst;
    logic                  r_valid;
    logic                  w_flush;
    logic                  w_req;
    logic                  w_issue;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign w_flush = EX_BranchFlag | Ctrl_ExcpFlag;

    always_comb begin
        w_next  = r_state;
        w_req   = 1'b0;
        w_issue = 1'b0;
        w_addr  = r_req_addr;
        case (r_state)
            S_BOOT: begin
                w_req  = 1'b1;
                w_addr = START_PC;
                w_next = S_WAIT;
            end
            S_WAIT: begin
                w_req = 1'b1;
                if (Icache_Valid && !w_flush && !r_drop)
                    w_next = S_HOLD;
            end
            S_HOLD: begin
                // Flush overrides stall: the redirect target must be fetched now.
                if (w_flush || !Ctrl_Stall) begin
                    w_req   = 1'b1;
                    w_issue = 1'b1;
                    w_addr  = Fetch_NextPC;
                    w_next  = S_WAIT;
                end
            end
            default: w_next = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_BOOT;
            r_req_addr <= START_PC;
            r_redirect <= START_PC;
            r_drop     <= 1'b0;
            r_now_pc   <= START_PC;
            r_inst     <= NOP_INST;
            r_valid    <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_WAIT: begin
                    if (Icache_Valid) begin
                        if (w_flush) begin
                            r_req_addr <= Fetch_NextPC;
                            r_drop     <= 1'b0;
                        end else if (r_drop) begin
                            r_req_addr <= r_redirect;
                            r_drop     <= 1'b0;
                        end else begin
                            r_now_pc <= r_req_addr;
                            r_inst   <= Icache_Data;
                            r_valid  <= 1'b1;
                        end
                    end else if (w_flush) begin
                        // Address must stay put until the in-flight response returns.
                        r_redirect <= Fetch_NextPC;
                        r_drop     <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_issue) begin
                        r_req_addr <= Fetch_NextPC;
                        r_valid    <= 1'b0;
                        r_inst     <= NOP_INST;
                    end
                end
                default: ;
            endcase
        end
    end

    assign IFID_IcacheReq  = w_req & rst_n;
    assign IFID_IcacheAddr = w_addr;
    assign IFID_NowPC      = r_now_pc;
    assign IFID_Inst       = r_inst;
    assign IFID_Valid      = r_valid;

endmodule

// File: doc/ifid_fetch_stage.md
IFID_FETCH_STAGE -- requirements
Module: ifid_fetch_stage

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the PC and Icache address width.
REQ-002 The block SHALL have parameter INST_WIDTH, default 32, meaning the instruction word width.
REQ-003 The block SHALL have parameter START_PC, default 32'h8000_0000, meaning the first fetch address after reset.
REQ-004 The block SHALL have parameter NOP_INST, default 32'h0000_0013, meaning the bubble instruction presented when IFID is empty.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port Fetch_NextPC, input, ADDR_WIDTH bits: next-PC from the PC-select logic, already including branch/exception redirect.
REQ-008 The block SHALL have port EX_BranchFlag, input, 1 bit: branch redirect, acts as flush.
REQ-009 The block SHALL have port Ctrl_ExcpFlag, input, 1 bit: exception redirect, acts as flush.
REQ-010 The block SHALL have port Ctrl_Stall, input, 1 bit: decode cannot accept; IFID holds.
REQ-011 The block SHALL have port IFID_IcacheReq, output, 1 bit: fetch request.
REQ-012 The block SHALL have port IFID_IcacheAddr, output, ADDR_WIDTH bits: fetch address.
REQ-013 The block SHALL have port Icache_Valid, input, 1 bit: response for the outstanding request.
REQ-014 The block SHALL have port Icache_Data, input, INST_WIDTH bits: fetched instruction.
REQ-015 The block SHALL have port IFID_NowPC, output, ADDR_WIDTH bits: PC of the instruction in IFID, fed back to PC-select.
REQ-016 The block SHALL have port IFID_Inst, output, INST_WIDTH bits: instruction presented to decode.
REQ-017 The block SHALL have port IFID_Valid, output, 1 bit: IFID_Inst is a live instruction.

Function
REQ-018 The FSM SHALL have states BOOT, WAIT, HOLD; at most one Icache request outstanding at any time.
REQ-019 BOOT: IFID_IcacheReq=1, IFID_IcacheAddr=START_PC, next state WAIT.
REQ-020 WAIT: IFID_IcacheReq=1, IFID_IcacheAddr held stable from the issuing cycle until the cycle Icache_Valid=1, inclusive.
REQ-021 Icache_Valid SHALL be ignored whenever IFID_IcacheReq=0.
REQ-022 WAIT with Icache_Valid=1 and no pending drop: next cycle IFID_NowPC=request addr, IFID_Inst=Icache_Data, IFID_Valid=1, state HOLD.
REQ-023 HOLD with Ctrl_Stall=1 and no flush: IFID_NowPC, IFID_Inst, IFID_Valid unchanged, IFID_IcacheReq=0.
REQ-024 HOLD with Ctrl_Stall=0: same cycle IFID_IcacheReq=1, IFID_IcacheAddr=Fetch_NextPC; next cycle IFID_Valid=0, IFID_Inst=NOP_INST, state WAIT.
REQ-025 Flush = EX_BranchFlag | Ctrl_ExcpFlag; flush SHALL take priority over Ctrl_Stall.
REQ-026 HOLD with flush: same cycle issue request at Fetch_NextPC; next cycle IFID_Valid=0, IFID_Inst=NOP_INST, state WAIT.
REQ-027 WAIT with flush and no Icache_Valid: capture Fetch_NextPC into a redirect register, set drop flag; keep current address until response.
REQ-028 WAIT with drop flag set and Icache_Valid=1: discard data, IFID unchanged-invalid, issue redirect address next cycle, clear drop flag.
REQ-029 WAIT with flush and Icache_Valid=1 same cycle: discard data, issue Fetch_NextPC of that cycle next cycle, IFID_Valid=0.
REQ-030 A second flush while drop flag is set SHALL overwrite the redirect register (latest target wins).
REQ-031 IFID_IcacheAddr bit 0 SHALL equal Fetch_NextPC bit 0 with no correction; alignment is the PC-select logic's responsibility.
REQ-032 Minimum steady-state throughput: one instruction per two cycles with zero-wait Icache (issue, response).

Reset
REQ-033 While rst_n=0, state=BOOT, IFID_NowPC=START_PC, IFID_Inst=NOP_INST, IFID_Valid=0, IFID_IcacheReq=0, drop flag=0, redirect register=START_PC.
REQ-034 Reset asserted mid-request SHALL abandon the request; the first request after release is START_PC.

Verification
REQ-035 Reset release, Icache_Valid one cycle after req with 32'h0000_0093 -> req addr 32'h8000_0000, IFID_NowPC=32'h8000_0000, IFID_Inst=32'h0000_0093, IFID_Valid=1.
REQ-036 HOLD, Ctrl_Stall=1 for 3 cycles -> IFID outputs constant, IFID_IcacheReq=0; on release req at Fetch_NextPC=32'h8000_0004.
REQ-037 WAIT, Icache_Valid delayed 4 cycles -> IFID_IcacheAddr stable all 4 cycles, single response accepted.
REQ-038 WAIT, EX_BranchFlag=1 with Fetch_NextPC=32'h8000_0100, response 2 cycles later -> response discarded, next req addr 32'h8000_0100, no IFID_Valid for stale data.
REQ-039 HOLD, Ctrl_Stall=1 and Ctrl_ExcpFlag=1 with Fetch_NextPC=32'h8000_0200 -> same-cycle req at 32'h8000_0200, IFID_Valid=0 next cycle.
REQ-040 rst_n low during WAIT -> all outputs at reset values asynchronously; late Icache_Valid ignored; first req after release at START_PC.
